cwalk_ctrl: RTL and testbench

//  Parametrised pedestrian-crossing controller, successor to the fixed-timing crosswalk FSM.
//  - Adds a latched pedestrian request, a minimum don't-walk interval, an auto-cycle mode,
//    a blinking hand during countdown, and an internal per-second prescaler.
//  - Sits under the board top. Drives walk/hand symbols and the countdown digit through the 7-seg scan mux.
//  - req_i is already synchronised and debounced by the top.

---
 rtl/cwalk_ctrl_pkg.sv | 20 ++
 rtl/cwalk_tick.sv | 31 +++
 rtl/cwalk_ctrl.sv | 128 ++++++++++++
 tb/tb_cwalk_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cwalk_ctrl_pkg.sv
// Shared definitions for the crosswalk controller: state encoding and
// elaboration-time width helpers.
package cwalk_ctrl_pkg;

    // Encoding 2'd3 is unused; the FSM falls back to HAND if it ever appears.
    typedef enum logic [1:0] {
        ST_HAND  = 2'd0,
        ST_WALK  = 2'd1,
        ST_COUNT = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int pc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/cwalk_tick.sv
// Timing-tick prescaler: pc counts 0..TICK_DIV-1 and pulses tick on the
// last count. i_clr restarts the count so every state starts on a fresh tick.
module cwalk_tick #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PC_W     = 26
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i_clr,
    output logic            o_tick,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    assign o_tick = (r_pc == PC_W'(TICK_DIV - 1));
    assign o_pc   = r_pc;

    // NOTE: reset is sampled on the clock edge, and all state updates use <=
    // so every register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_pc <= '0;
        end else if (o_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/cwalk_ctrl.sv
// Pedestrian-crossing controller: HAND -> WALK -> COUNT cycle with latched
// requests, a minimum don't-walk interval, auto-cycle mode and blinking hand.
module cwalk_ctrl
    import cwalk_ctrl_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int MIN_HAND_SECS = 10,
    parameter int WALK_SECS     = 5,
    parameter int CNTDWN_SECS   = 9,
    parameter int NUM_W         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_i,
    input  logic             auto_mode,
    output logic             walk,
    output logic             hand,
    output logic             num_on,
    output logic [NUM_W-1:0] num,
    output logic             req_pending
);

    localparam int PC_W   = pc_width(TICK_DIV);
    localparam int SECS_W = $clog2(max_int(MIN_HAND_SECS, WALK_SECS) + 1);

    if (TICK_DIV < 2 || (TICK_DIV % 2) != 0 || MIN_HAND_SECS < 1 || WALK_SECS < 1 ||
        NUM_W < 1 || CNTDWN_SECS < 0 || CNTDWN_SECS > (2**NUM_W) - 1) begin : g_param_check
        $error("cwalk_ctrl: illegal parameter combination");
    end

    state_t            r_state, w_state_nxt;
    logic [PC_W-1:0]   w_pc;
    logic              w_tick;
    logic              w_state_chg;
    logic              w_min_done;
    logic              w_go_walk;
    logic              w_req_edge;
    logic [SECS_W-1:0] r_secs;
    logic [NUM_W-1:0]  r_num;
    logic              r_req_q;
    logic              r_req_pending;

    cwalk_tick #(
        .TICK_DIV (TICK_DIV),
        .PC_W     (PC_W)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_state_chg),
        .o_tick  (w_tick),
        .o_pc    (w_pc)
    );

    assign w_min_done  = (r_secs == SECS_W'(MIN_HAND_SECS)) ||
                         (w_tick && r_secs == SECS_W'(MIN_HAND_SECS - 1));
    assign w_req_edge  = req_i && !r_req_q;
    assign w_state_chg = (w_state_nxt != r_state);

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_go_walk   = 1'b0;
        case (r_state)
            ST_HAND: begin
                if (w_min_done && (r_req_pending || auto_mode)) begin
                    w_state_nxt = ST_WALK;
                    w_go_walk   = 1'b1;
                end
            end
            ST_WALK: begin
                if (w_tick && r_secs == SECS_W'(WALK_SECS - 1)) begin
                    w_state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (w_tick && r_num == '0) begin
                    w_state_nxt = ST_HAND;
                end
            end
            default: w_state_nxt = ST_HAND;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_HAND;
            r_secs        <= '0;
            r_num         <= '0;
            r_req_q       <= 1'b0;
            r_req_pending <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req_q <= req_i;

            // secs saturates at the HAND minimum; COUNT timing uses num instead.
            if (w_state_chg) begin
                r_secs <= '0;
            end else if (w_tick && (r_state == ST_WALK ||
                         (r_state == ST_HAND && r_secs != SECS_W'(MIN_HAND_SECS)))) begin
                r_secs <= r_secs + SECS_W'(1);
            end

            // Leaving COUNT on num==0 forces 0, so the decrement never wraps.
            if (w_state_nxt != ST_COUNT) begin
                r_num <= '0;
            end else if (r_state == ST_WALK) begin
                r_num <= NUM_W'(CNTDWN_SECS);
            end else if (w_tick) begin
                r_num <= r_num - NUM_W'(1);
            end

            if (w_go_walk) begin
                r_req_pending <= 1'b0;
            end else if (w_req_edge && r_state != ST_WALK && !auto_mode) begin
                r_req_pending <= 1'b1;
            end
        end
    end

    assign walk        = (r_state == ST_WALK);
    assign hand        = (r_state == ST_HAND) ||
                         (r_state == ST_COUNT && w_pc < PC_W'(TICK_DIV / 2));
    assign num_on      = (r_state == ST_COUNT);
    assign num         = r_num;
    assign req_pending = r_req_pending;

endmodule

// File: tb/tb_cwalk_ctrl.sv
// Directed bench for cwalk_ctrl with TICK_DIV=4, MIN_HAND_SECS=2,
// WALK_SECS=2, CNTDWN_SECS=3; cycle 0 is the first cycle after reset release.
module tb_cwalk_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_i;
    logic       auto_mode;
    logic       walk;
    logic       hand;
    logic       num_on;
    logic [3:0] num;
    logic       req_pending;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    cwalk_ctrl #(
        .TICK_DIV      (4),
        .MIN_HAND_SECS (2),
        .WALK_SECS     (2),
        .CNTDWN_SECS   (3),
        .NUM_W         (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       (req_i),
        .auto_mode   (auto_mode),
        .walk        (walk),
        .hand        (hand),
        .num_on      (num_on),
        .num         (num),
        .req_pending (req_pending)
    );

    always #5 clk = ~clk;

    // Packed view {walk, hand, num_on, num[3:0], req_pending}.
    function automatic logic [7:0] pack_out(input logic w, input logic h, input logic no,
                                             input logic [3:0] n, input logic rp);
        return {w, h, no, n, rp};
    endfunction

    // Expected outputs d cycles after a walk starts (d<0 or d>=24: HAND).
    function automatic logic [7:0] exp_phase(input int d, input logic rp);
        int k;
        if (d >= 0 && d < 8) return pack_out(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        if (d >= 8 && d < 24) begin
            k = d - 8;
            return pack_out(1'b0, (k % 4) < 2, 1'b1, 4'(3 - k / 4), rp);
        end
        return pack_out(1'b0, 1'b1, 1'b0, 4'd0, rp);
    endfunction

    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {walk, hand, num_on, num, req_pending};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %b expected %b (walk,hand,num_on,num,req_pending)",
                   tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_i   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        logic rp;
        reset_n   = 1'b0;
        req_i     = 1'b0;
        auto_mode = 1'b0;

        // Reset state after three reset cycles.
        do_reset();
        check("reset", pack_out(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));

        // Request at 2 serves a full cycle; the edge at 10 lands in WALK and is dropped.
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            req_i = (cyc == 2 || cyc == 10);
            rp    = (cyc >= 3 && cyc < 8);
            check("req_cycle", exp_phase(cyc - 8, rp));
            next_cycle();
        end

        // Request edge during COUNT is latched and served after the HAND minimum.
        do_reset();
        for (int c = 0; c <= 48; c++) begin
            req_i = (cyc == 2 || cyc == 20);
            rp    = (cyc >= 3 && cyc < 8) || (cyc >= 21 && cyc < 40);
            check("count_req", exp_phase((cyc >= 40) ? cyc - 40 : cyc - 8, rp));
            next_cycle();
        end

        // Auto mode cycles every 32 cycles; presses never latch a request.
        auto_mode = 1'b1;
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            req_i = (cyc == 2 || cyc == 20 || cyc == 50);
            check("auto", exp_phase((cyc >= 8) ? (cyc - 8) % 32 : -1, 1'b0));
            next_cycle();
        end
        auto_mode = 1'b0;
        req_i     = 1'b0;

        // Reset mid-WALK aborts; a new request walks 8 cycles after release.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            req_i = (cyc == 2);
            check("pre_abort", exp_phase(cyc - 8, cyc >= 3 && cyc < 8));
            next_cycle();
        end
        reset_n = 1'b0;
        next_cycle();
        check("abort", pack_out(1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        reset_n = 1'b1;
        cyc     = 0;
        for (int c = 0; c <= 20; c++) begin
            req_i = (cyc == 2);
            check("restart", exp_phase(cyc - 8, cyc >= 3 && cyc < 8));
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
